// File: rtl/flag_pkg.sv
// flag_pkg: shared definitions for the processor-status flag path.
//   FLAG_* : bit positions of the ALU flags inside a flag vector
//   FLAG_W : default flag-vector width
//   flag_t : flag vector type for ALU producers and branch-condition decode
//   stk_req_t : raw push/pop request bundle into the shadow stack
package flag_pkg;
  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;
  localparam int FLAG_W = 5;

  typedef logic [FLAG_W-1:0] flag_t;

  typedef struct packed {
    logic push;
    logic pop;
  } stk_req_t;
endpackage

// File: rtl/flag_lifo.sv
// flag_lifo: LIFO shadow stack for flag context.
//   clk, reset : clock, synchronous active-high reset (clears depth only)
//   req        : raw push/pop request; push+pop on a non-empty stack is a swap
//   wdata      : value saved on push/swap (live flags before the edge)
//   rdata      : current stack top, stack[depth-1]
//   depth      : valid entries; full/empty decoded from it
//   pop_ok     : a pop or swap is being accepted this cycle (live flags take rdata)
//   ovf, unf   : single-cycle error events for the sticky bits in the wrapper
module flag_lifo
  import flag_pkg::*;
#(
  parameter  int WIDTH = FLAG_W,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  stk_req_t         req,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             pop_ok,
  output logic             ovf,
  output logic             unf
);
  // Storage is sized to the full range of the depth counter so it can be
  // indexed without resizing; slots at DEPTH and above are never written.
  localparam int SLOTS = 1 << CW;

  logic [WIDTH-1:0] mem [SLOTS];
  logic [CW-1:0]    top_idx;
  logic             push_eff;
  logic             push_ok;
  logic             swap;

  assign full    = (depth == CW'(DEPTH));
  assign empty   = (depth == '0);
  assign top_idx = depth - CW'(1);
  assign rdata   = mem[top_idx];

  // A swap needs a non-empty stack; on an empty stack push+pop degrades to
  // a plain push (with its own full check) and still flags the underflow.
  assign pop_ok   = req.pop & ~empty;
  assign swap     = req.push & pop_ok;
  assign push_eff = req.push & ~pop_ok;
  assign push_ok  = push_eff & ~full;
  assign ovf      = push_eff & full;
  assign unf      = req.pop & empty;

  always_ff @(posedge clk) begin
    if (reset) depth <= '0;
    else if (push_ok) depth <= depth + CW'(1);
    else if (pop_ok && !swap) depth <= depth - CW'(1);
  end

  // Storage is not reset: entries at or above depth are never observable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push_ok) mem[depth] <= wdata;
      else if (swap) mem[top_idx] <= wdata;
    end
  end
endmodule

// File: rtl/flag_ctx_reg.sv
// flag_ctx_reg: live processor-status flag register with masked ALU updates,
// full-word software load and a shadow stack for context save/restore.
//   clk, reset       : clock, synchronous active-high reset
//   flag_in/flag_we  : ALU flag values and per-bit update mask
//   sw_in/sw_we      : software PSR load of all live flags
//   push/pop         : save / restore live flags (both = swap with stack top)
//   err_clr          : clear sticky errors (a same-cycle error wins)
//   flags_out        : live flags
//   depth/full/empty : shadow-stack occupancy
//   ovf_err/unf_err  : sticky push-while-full / pop-while-empty
module flag_ctx_reg
  import flag_pkg::*;
#(
  parameter  int WIDTH = FLAG_W,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] flag_in,
  input  logic [WIDTH-1:0] flag_we,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             sw_we,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [WIDTH-1:0] flags_out,
  output logic [CW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err
);
  logic [WIDTH-1:0] stk_top;
  logic             pop_ok;
  logic             ovf;
  logic             unf;
  stk_req_t         req;

  assign req = '{push: push, pop: pop};

  flag_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lifo (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .wdata  (flags_out),
    .rdata  (stk_top),
    .depth  (depth),
    .full   (full),
    .empty  (empty),
    .pop_ok (pop_ok),
    .ovf    (ovf),
    .unf    (unf)
  );

  // Restore beats software load beats masked ALU update.
  always_ff @(posedge clk) begin
    if (reset) flags_out <= '0;
    else if (pop_ok) flags_out <= stk_top;
    else if (sw_we) flags_out <= sw_in;
    else flags_out <= (flags_out & ~flag_we) | (flag_in & flag_we);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      ovf_err <= ovf | (ovf_err & ~err_clr);
      unf_err <= unf | (unf_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_flag_ctx_reg.sv
module tb_flag_ctx_reg;
  localparam int W  = 5;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset, sw_we, push, pop, err_clr;
  logic [W-1:0]  flag_in, flag_we, sw_in, flags_out;
  logic [CW-1:0] depth;
  logic          full, empty, ovf_err, unf_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] flags;
    int           dep;
    logic         ovf;
    logic         unf;
  } exp_t;

  exp_t sb[$];

  flag_ctx_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .flag_in(flag_in), .flag_we(flag_we),
    .sw_in(sw_in), .sw_we(sw_we), .push(push), .pop(pop), .err_clr(err_clr),
    .flags_out(flags_out), .depth(depth), .full(full), .empty(empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string fld, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge state, then
  // compare once the edge has been taken.
  task automatic step(input string tag, input logic rst, input logic ps, input logic pp,
                      input logic swe, input logic [W-1:0] swi,
                      input logic [W-1:0] fwe, input logic [W-1:0] fin, input logic ec,
                      input logic [W-1:0] e_flags, input int e_dep,
                      input logic e_ovf, input logic e_unf);
    exp_t e;
    reset = rst; push = ps; pop = pp; sw_we = swe; sw_in = swi;
    flag_we = fwe; flag_in = fin; err_clr = ec;
    sb.push_back('{tag, e_flags, e_dep, e_ovf, e_unf});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.tag, "flags", int'(flags_out), int'(e.flags));
    check(e.tag, "depth", int'(depth), e.dep);
    check(e.tag, "full",  int'(full),  (e.dep == D) ? 1 : 0);
    check(e.tag, "empty", int'(empty), (e.dep == 0) ? 1 : 0);
    check(e.tag, "ovf",   int'(ovf_err), int'(e.ovf));
    check(e.tag, "unf",   int'(unf_err), int'(e.unf));
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; sw_we = 1'b0; err_clr = 1'b0;
    sw_in = '0; flag_we = '0; flag_in = '0;
    #2;
    //     tag        rst ps pp swe swi    fwe    fin    ec  flags  dep ovf unf
    step("reset",     1, 1, 0, 1, 5'h1F, 5'h00, 5'h00, 0, 5'h00, 0, 0, 0);
    step("sw_load",   0, 0, 0, 1, 5'h15, 5'h00, 5'h00, 0, 5'h15, 0, 0, 0);
    step("masked",    0, 0, 0, 0, 5'h00, 5'h03, 5'h0A, 0, 5'h16, 0, 0, 0);
    step("sw_prio",   0, 0, 0, 1, 5'h0C, 5'h03, 5'h0A, 0, 5'h0C, 0, 0, 0);
    // nesting: each push saves the pre-edge value while the live word moves on
    step("set01",     0, 0, 0, 1, 5'h01, 5'h00, 5'h00, 0, 5'h01, 0, 0, 0);
    step("push1",     0, 1, 0, 1, 5'h02, 5'h00, 5'h00, 0, 5'h02, 1, 0, 0);
    step("push2",     0, 1, 0, 1, 5'h03, 5'h00, 5'h00, 0, 5'h03, 2, 0, 0);
    step("push3",     0, 1, 0, 1, 5'h04, 5'h00, 5'h00, 0, 5'h04, 3, 0, 0);
    step("push4",     0, 1, 0, 1, 5'h05, 5'h00, 5'h00, 0, 5'h05, 4, 0, 0);
    step("push_ovf",  0, 1, 0, 0, 5'h00, 5'h1F, 5'h06, 0, 5'h06, 4, 1, 0);
    step("pop1",      0, 0, 1, 1, 5'h1F, 5'h1F, 5'h1F, 0, 5'h04, 3, 1, 0);
    step("pop2",      0, 0, 1, 0, 5'h00, 5'h00, 5'h00, 0, 5'h03, 2, 1, 0);
    step("pop3",      0, 0, 1, 0, 5'h00, 5'h00, 5'h00, 0, 5'h02, 1, 1, 0);
    step("pop4",      0, 0, 1, 0, 5'h00, 5'h00, 5'h00, 0, 5'h01, 0, 1, 0);
    step("clr_ovf",   0, 0, 0, 0, 5'h00, 5'h00, 5'h00, 1, 5'h01, 0, 0, 0);
    // underflow: pop ignored, ALU write still lands
    step("pop_unf",   0, 0, 1, 0, 5'h00, 5'h1F, 5'h11, 0, 5'h11, 0, 0, 1);
    step("clr_unf",   0, 0, 0, 0, 5'h00, 5'h00, 5'h00, 1, 5'h11, 0, 0, 0);
    step("clr_vs_ev", 0, 0, 1, 0, 5'h00, 5'h00, 5'h00, 1, 5'h11, 0, 0, 1);
    step("clr_unf2",  0, 0, 0, 0, 5'h00, 5'h00, 5'h00, 1, 5'h11, 0, 0, 0);
    // swap
    step("set15",     0, 0, 0, 1, 5'h15, 5'h00, 5'h00, 0, 5'h15, 0, 0, 0);
    step("push15",    0, 1, 0, 1, 5'h0A, 5'h00, 5'h00, 0, 5'h0A, 1, 0, 0);
    step("swap",      0, 1, 1, 1, 5'h1F, 5'h00, 5'h00, 0, 5'h15, 1, 0, 0);
    step("pop_swap",  0, 0, 1, 0, 5'h00, 5'h00, 5'h00, 0, 5'h0A, 0, 0, 0);
    // swap on empty stack: acts as a push and flags underflow
    step("swap_empty",0, 1, 1, 0, 5'h00, 5'h00, 5'h00, 0, 5'h0A, 1, 0, 1);
    step("pop_se",    0, 0, 1, 0, 5'h00, 5'h00, 5'h00, 0, 5'h0A, 0, 0, 1);
    step("clr_se",    0, 0, 0, 0, 5'h00, 5'h00, 5'h00, 1, 5'h0A, 0, 0, 0);
    // mid-operation reset
    step("set03",     0, 0, 0, 1, 5'h03, 5'h00, 5'h00, 0, 5'h03, 0, 0, 0);
    step("pushA",     0, 1, 0, 0, 5'h00, 5'h00, 5'h00, 0, 5'h03, 1, 0, 0);
    step("pushB",     0, 1, 0, 0, 5'h00, 5'h00, 5'h00, 0, 5'h03, 2, 0, 0);
    step("rst_push",  1, 1, 0, 1, 5'h1F, 5'h1F, 5'h1F, 0, 5'h00, 0, 0, 0);
    step("pop_after", 0, 0, 1, 0, 5'h00, 5'h00, 5'h00, 0, 5'h00, 0, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
